// File: rtl/vad.sv
// Voice-activity detector: decimates a 1-bit PDM stream to PCM by ones-counting,
// accumulates the absolute PCM deviation from mid-scale over a frame, and runs
// an onset/hangover state machine on the resulting frame energies.
module vad #(
   parameter int WINDOW          = 64,
   parameter int FRAME           = 256,
   parameter int THRESHOLD       = 2048,
   parameter int ONSET_FRAMES    = 2,
   parameter int HANGOVER_FRAMES = 8,
   localparam int EW             = $clog2(WINDOW / 2 * FRAME + 1)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          pdm_data_i,
   input  logic          pdm_valid_i,
   output logic          vad_o,
   output logic [EW-1:0] energy_o,
   output logic          energy_valid_o
);

   localparam int OW   = $clog2(WINDOW + 1);
   localparam int SW   = $clog2(WINDOW);
   localparam int DW   = $clog2(WINDOW / 2 + 1);
   localparam int FW   = (FRAME > 1) ? $clog2(FRAME) : 1;
   localparam int RMAX = (ONSET_FRAMES > HANGOVER_FRAMES) ? ONSET_FRAMES : HANGOVER_FRAMES;
   localparam int RW   = $clog2(RMAX + 1);

   localparam logic [OW-1:0] HALF = OW'(WINDOW / 2);

   typedef enum logic [1:0] {
      QUIET,
      ONSET,
      ACTIVE,
      HANGOVER
   } state_t;

   logic [SW-1:0] samp_cnt;
   logic [OW-1:0] ones_cnt;
   logic [FW-1:0] frame_cnt;
   logic [EW-1:0] acc;
   logic [OW-1:0] pcm_c;
   logic [DW-1:0] dev;
   logic [EW-1:0] acc_next;
   logic          win_last;
   logic          frame_last;

   state_t        state;
   logic [RW-1:0] run_cnt;
   logic [RW-1:0] run_inc;
   logic          loud;

   assign win_last   = (samp_cnt == SW'(WINDOW - 1));
   assign frame_last = (frame_cnt == FW'(FRAME - 1));
   assign loud       = (int'(energy_o) >= THRESHOLD);
   assign run_inc    = run_cnt + RW'(1);

   // PCM value of the closing window (current bit included) and its distance from mid-scale
   // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
   always_comb begin
      pcm_c = ones_cnt + OW'(pdm_data_i);
      if (pcm_c >= HALF) dev = DW'(pcm_c - HALF);
      else               dev = DW'(HALF - pcm_c);
      acc_next = acc + EW'(dev);
   end

   // Decimator and frame accumulator; everything advances only on a PDM strobe
   // NOTE: state registers use non-blocking assignments so all updates land together on the edge.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         samp_cnt       <= '0;
         ones_cnt       <= '0;
         frame_cnt      <= '0;
         acc            <= '0;
         energy_o       <= '0;
         energy_valid_o <= 1'b0;
      end else begin
         energy_valid_o <= 1'b0;
         if (pdm_valid_i) begin
            if (win_last) begin
               samp_cnt <= '0;
               ones_cnt <= '0;
               if (frame_last) begin
                  frame_cnt      <= '0;
                  acc            <= '0;
                  energy_o       <= acc_next;
                  energy_valid_o <= 1'b1;
               end else begin
                  frame_cnt <= frame_cnt + FW'(1);
                  acc       <= acc_next;
               end
            end else begin
               samp_cnt <= samp_cnt + SW'(1);
               ones_cnt <= ones_cnt + OW'(pdm_data_i);
            end
         end
      end
   end

   // Onset/hangover state machine, evaluated once per completed frame
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state   <= QUIET;
         run_cnt <= '0;
         vad_o   <= 1'b0;
      end else if (energy_valid_o) begin
         case (state)
            QUIET: begin
               if (loud) begin
                  run_cnt <= RW'(1);
                  if (ONSET_FRAMES == 1) begin
                     state <= ACTIVE;
                     vad_o <= 1'b1;
                  end else begin
                     state <= ONSET;
                  end
               end
            end
            ONSET: begin
               if (loud) begin
                  run_cnt <= run_inc;
                  if (int'(run_inc) >= ONSET_FRAMES) begin
                     state <= ACTIVE;
                     vad_o <= 1'b1;
                  end
               end else begin
                  state   <= QUIET;
                  run_cnt <= '0;
               end
            end
            ACTIVE: begin
               if (!loud) begin
                  if (HANGOVER_FRAMES == 0) begin
                     state   <= QUIET;
                     run_cnt <= '0;
                     vad_o   <= 1'b0;
                  end else begin
                     state   <= HANGOVER;
                     run_cnt <= RW'(1);
                  end
               end
            end
            HANGOVER: begin
               if (loud) begin
                  state   <= ACTIVE;
                  run_cnt <= '0;
               end else if (int'(run_inc) >= HANGOVER_FRAMES) begin
                  state   <= QUIET;
                  run_cnt <= '0;
                  vad_o   <= 1'b0;
               end else begin
                  run_cnt <= run_inc;
               end
            end
            default: begin
               state   <= QUIET;
               run_cnt <= '0;
               vad_o   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vad.sv
// Bench for vad with WINDOW=8, FRAME=4, THRESHOLD=8, ONSET_FRAMES=2, HANGOVER_FRAMES=3.
// A table of frames (PDM pattern, expected energy, expected vad) is played twice,
// gap-free and with random strobe gaps; frame energies go through a scoreboard queue.
module tb_vad;

   localparam int EW = 5;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          pdm_data_i;
   logic          pdm_valid_i;
   logic          vad_o;
   logic [EW-1:0] energy_o;
   logic          energy_valid_o;

   int tests = 0;
   int fails = 0;
   logic [31:0] sb[$];
   logic cur_vad = 1'b0;

   typedef struct {
      logic [7:0] pattern;
      int         energy;
      logic       vad;
   } vec_t;

   vec_t vecs[16];

   vad #(
      .WINDOW(8), .FRAME(4), .THRESHOLD(8), .ONSET_FRAMES(2), .HANGOVER_FRAMES(3)
   ) dut (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .pdm_data_i(pdm_data_i),
      .pdm_valid_i(pdm_valid_i),
      .vad_o(vad_o),
      .energy_o(energy_o),
      .energy_valid_o(energy_valid_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      tests++;
      if (actual !== expected) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Drives one 32-strobe frame; called and returns on a falling edge.
   task automatic drive_frame(input logic [7:0] pat, input int exp_e, input logic exp_v,
                              input bit gaps);
      logic early;
      early = 1'b0;
      sb.push_back(32'(exp_e));
      for (int w = 0; w < 4; w++) begin
         for (int i = 0; i < 8; i++) begin
            bit last;
            int gap;
            last = (w == 3) && (i == 7);
            gap  = (gaps && !last) ? int'($urandom_range(0, 5)) : 0;
            pdm_data_i  = pat[i];
            pdm_valid_i = 1'b1;
            @(negedge clk_i);
            pdm_valid_i = 1'b0;
            if (!last && energy_valid_o) early = 1'b1;
            repeat (gap) begin
               @(negedge clk_i);
               if (energy_valid_o) early = 1'b1;
            end
         end
      end
      check("early_pulse", 32'(early), 0);
      check("pulse_latency", 32'(energy_valid_o), 1);
      check("vad_hold", 32'(vad_o), 32'(cur_vad));
      @(negedge clk_i);
      check("pulse_width", 32'(energy_valid_o), 0);
      check("vad_update", 32'(vad_o), 32'(exp_v));
      cur_vad = exp_v;
   endtask

   task automatic run_table(input bit gaps);
      for (int r = 0; r < 16; r++)
         drive_frame(vecs[r].pattern, vecs[r].energy, vecs[r].vad, gaps);
   endtask

   // Scoreboard: every energy pulse must match the oldest outstanding expectation
   initial begin
      forever begin
         @(negedge clk_i);
         if (energy_valid_o === 1'b1) begin
            if (sb.size() == 0) check("unexpected_pulse", 32'(energy_valid_o), 0);
            else                check("energy", 32'(energy_o), sb.pop_front());
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0]  = '{8'b0101_0101, 0,  1'b0};  // alternating: silent
      vecs[1]  = '{8'b0101_0101, 0,  1'b0};
      vecs[2]  = '{8'hFF,        16, 1'b0};  // loud -> ONSET
      vecs[3]  = '{8'b0101_0101, 0,  1'b0};  // quiet -> back to QUIET
      vecs[4]  = '{8'hFF,        16, 1'b0};  // first loud: no vad yet
      vecs[5]  = '{8'b0101_0101, 0,  1'b0};
      vecs[6]  = '{8'b0011_1111, 8,  1'b0};  // energy == threshold is loud
      vecs[7]  = '{8'hFF,        16, 1'b1};  // second consecutive loud -> ACTIVE
      vecs[8]  = '{8'b0001_1111, 4,  1'b1};  // 5 ones: quiet, hangover 1
      vecs[9]  = '{8'b0101_0101, 0,  1'b1};  // hangover 2
      vecs[10] = '{8'hFF,        16, 1'b1};  // loud inside hangover -> ACTIVE
      vecs[11] = '{8'b0101_0101, 0,  1'b1};
      vecs[12] = '{8'b0101_0101, 0,  1'b1};
      vecs[13] = '{8'b0101_0101, 0,  1'b0};  // third quiet frame releases
      vecs[14] = '{8'h00,        16, 1'b0};  // all zeros also loud
      vecs[15] = '{8'h03,        8,  1'b1};  // 2 ones: d = 2, loud -> ACTIVE

      rst_i       = 1'b1;
      pdm_data_i  = 1'b0;
      pdm_valid_i = 1'b0;
      repeat (3) @(negedge clk_i);
      check("reset_vad", 32'(vad_o), 0);
      check("reset_energy", 32'(energy_o), 0);
      check("reset_valid", 32'(energy_valid_o), 0);
      rst_i = 1'b0;
      @(negedge clk_i);

      run_table(1'b0);

      // Reset mid-frame while ACTIVE, with strobes present during reset
      for (int i = 0; i < 10; i++) begin
         pdm_data_i  = 1'b1;
         pdm_valid_i = 1'b1;
         @(negedge clk_i);
      end
      pdm_valid_i = 1'b0;
      rst_i       = 1'b1;
      pdm_valid_i = 1'b1;
      @(negedge clk_i);
      check("midreset_vad", 32'(vad_o), 0);
      check("midreset_energy", 32'(energy_o), 0);
      check("midreset_valid", 32'(energy_valid_o), 0);
      @(negedge clk_i);
      rst_i       = 1'b0;
      pdm_valid_i = 1'b0;
      cur_vad     = 1'b0;
      @(negedge clk_i);

      run_table(1'b1);

      repeat (3) @(negedge clk_i);
      check("scoreboard_drained", 32'(sb.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
